// File: rtl/march_sequencer.sv
// March C- sequencer: steps an external address counter through six elements and issues
// per-address read/write strobes with write data and expected read data.
module march_sequencer #(
    parameter int unsigned                ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0]      LAST_ADDR  = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic                  pause_in,
    input  logic [ADDR_WIDTH-1:0] tas_in,
    output logic                  hold_out,
    output logic                  updwn_out,
    output logic                  s_out,
    output logic                  r_out,
    output logic                  we_out,
    output logic                  re_out,
    output logic                  data_out,
    output logic                  exp_out,
    output logic [2:0]            elem_out,
    output logic                  busy_out,
    output logic                  done_out
);

    typedef enum logic [1:0] {StIdle, StInit, StOp, StDone} state_e;

    localparam logic [ADDR_WIDTH-1:0] AddrOne  = 1;
    localparam logic [ADDR_WIDTH-1:0] AddrZero = '0;

    state_e                r_state;
    logic [2:0]            r_elem;
    logic                  r_op;
    logic                  r_pause;  // this cycle is frozen by a pause sampled last edge
    logic                  r_step;   // this cycle's final op steps the counter

    state_e                w_state_nxt;
    logic [2:0]            w_elem_nxt;
    logic                  w_op_nxt;
    logic                  w_pause_nxt;
    logic                  w_step_nxt;
    logic                  w_down;
    logic                  w_last_op;
    logic                  w_at_end;
    logic                  w_hold;
    logic                  w_nxt_down;
    logic                  w_nxt_last;
    logic [ADDR_WIDTH-1:0] w_addr_pred;

    assign w_down    = (r_elem >= 3'd3);
    assign w_last_op = (r_elem == 3'd0) || (r_elem == 3'd5) || r_op;
    assign w_at_end  = (tas_in == (w_down ? AddrZero : LAST_ADDR));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_elem  <= 3'd0;
            r_op    <= 1'b0;
            r_pause <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_op    <= w_op_nxt;
            r_pause <= w_pause_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Moore output decode
    always_comb begin
        w_hold    = 1'b1;
        updwn_out = 1'b0;
        s_out     = 1'b0;
        r_out     = 1'b0;
        we_out    = 1'b0;
        re_out    = 1'b0;
        data_out  = 1'b0;
        exp_out   = 1'b0;
        busy_out  = 1'b0;
        done_out  = 1'b0;
        unique case (r_state)
            StInit: begin
                busy_out  = 1'b1;
                updwn_out = w_down;
                if (!r_pause) begin
                    s_out = !w_down;
                    r_out = w_down;
                end
            end
            StOp: begin
                busy_out  = 1'b1;
                updwn_out = w_down;
                if (!r_pause) begin
                    w_hold = !r_step;
                    if (r_elem == 3'd0) begin
                        we_out = 1'b1;
                    end else if (r_elem == 3'd5) begin
                        re_out = 1'b1;
                    end else if (!r_op) begin
                        re_out  = 1'b1;
                        exp_out = !r_elem[0];
                    end else begin
                        we_out   = 1'b1;
                        data_out = r_elem[0];
                    end
                end
            end
            StDone:  done_out = 1'b1;
            default: ;
        endcase
    end

    assign hold_out = w_hold;
    assign elem_out = r_elem;

    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_op_nxt    = r_op;
        w_pause_nxt = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (start_in) begin
                    w_state_nxt = StInit;
                    w_elem_nxt  = 3'd0;
                    w_op_nxt    = 1'b0;
                    w_pause_nxt = pause_in;
                end
            end
            StInit: begin
                w_pause_nxt = pause_in;
                if (!r_pause) begin
                    w_state_nxt = StOp;
                    w_op_nxt    = 1'b0;
                end
            end
            StOp: begin
                w_pause_nxt = pause_in;
                if (!r_pause) begin
                    if (!w_last_op) begin
                        w_op_nxt = 1'b1;
                    end else if (!w_at_end) begin
                        w_op_nxt = 1'b0;
                    end else if (r_elem == 3'd5) begin
                        w_state_nxt = StDone;
                        w_op_nxt    = 1'b0;
                        w_pause_nxt = 1'b0;
                    end else begin
                        w_state_nxt = StInit;
                        w_elem_nxt  = r_elem + 3'd1;
                        w_op_nxt    = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Address the counter will show next cycle, so the step decision can be registered.
    always_comb begin
        if (r_state == StInit && !r_pause) begin
            w_addr_pred = w_down ? LAST_ADDR : AddrZero;
        end else if (!w_hold) begin
            w_addr_pred = w_down ? (tas_in - AddrOne) : (tas_in + AddrOne);
        end else begin
            w_addr_pred = tas_in;
        end
    end

    assign w_nxt_down = (w_elem_nxt >= 3'd3);
    assign w_nxt_last = (w_elem_nxt == 3'd0) || (w_elem_nxt == 3'd5) || w_op_nxt;
    assign w_step_nxt = (w_state_nxt == StOp) && w_nxt_last &&
                        (w_addr_pred != (w_nxt_down ? AddrZero : LAST_ADDR));

endmodule

// File: tb/tb_march_sequencer.sv
// Bench for march_sequencer: counter model, March C- reference stream and scoreboard.
module tb_march_sequencer;

    localparam int BaseBusy = 166;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_in = 1'b0;
    logic       pause_in = 1'b0;
    logic [3:0] tas = 4'h7;
    logic       hold_out, updwn_out, s_out, r_out, we_out, re_out, data_out, exp_out;
    logic [2:0] elem_out;
    logic       busy_out, done_out;

    march_sequencer #(.ADDR_WIDTH(4), .LAST_ADDR(4'hf)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .pause_in  (pause_in),
        .tas_in    (tas),
        .hold_out  (hold_out),
        .updwn_out (updwn_out),
        .s_out     (s_out),
        .r_out     (r_out),
        .we_out    (we_out),
        .re_out    (re_out),
        .data_out  (data_out),
        .exp_out   (exp_out),
        .elem_out  (elem_out),
        .busy_out  (busy_out),
        .done_out  (done_out)
    );

    always #5 clk = ~clk;

    // External address counter (no reset: INIT reloads it)
    always @(posedge clk) begin
        if (s_out)          tas <= 4'h0;
        else if (r_out)     tas <= 4'hf;
        else if (!hold_out) tas <= updwn_out ? tas - 4'h1 : tas + 4'h1;
    end

    typedef enum logic [1:0] {KInit, KRd, KWr} kind_e;
    typedef struct packed {
        kind_e      kind;
        logic [2:0] elem;
        logic [3:0] addr;
        logic       val;   // direction for INIT, data/expected bit for ops
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_err = 0;
    int    n_wr = 0;
    int    n_rd = 0;

    // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 dn(r0)
    int nops  [6] = '{1, 2, 2, 2, 2, 1};
    bit is_rd [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
    bit bval  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_run();
        item_t it;
        for (int e = 0; e < 6; e++) begin
            bit down = (e >= 3);
            it.kind = KInit; it.elem = 3'(e); it.addr = 4'h0; it.val = down;
            sb.push_back(it);
            for (int i = 0; i < 16; i++) begin
                for (int k = 0; k < nops[e]; k++) begin
                    it.kind = is_rd[e][k] ? KRd : KWr;
                    it.elem = 3'(e);
                    it.addr = down ? 4'(15 - i) : 4'(i);
                    it.val  = bval[e][k];
                    sb.push_back(it);
                end
            end
        end
    endtask

    // Monitor
    logic       pause_seen = 1'b0;
    logic       pause_prev = 1'b0;
    logic [3:0] prev_tas = 4'h0;
    item_t      mon_it;

    always @(posedge clk) pause_seen <= pause_in;

    always @(negedge clk) begin
        if (!rst) begin
            if (pause_seen && busy_out) begin
                chk("pause_quiet", int'({s_out, r_out, we_out, re_out}), 0);
                if (pause_prev) chk("pause_tas_stable", tas, prev_tas);
            end
            if (s_out || r_out || we_out || re_out) begin
                if (we_out) n_wr++;
                if (re_out) n_rd++;
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    mon_it = sb.pop_front();
                    chk("elem", elem_out, mon_it.elem);
                    if (mon_it.kind == KInit) begin
                        chk("init_s", s_out, !mon_it.val);
                        chk("init_r", r_out, mon_it.val);
                        chk("init_updwn", updwn_out, mon_it.val);
                    end else begin
                        chk("op_we", we_out, mon_it.kind == KWr);
                        chk("op_re", re_out, mon_it.kind == KRd);
                        chk("op_addr", tas, mon_it.addr);
                        if (mon_it.kind == KWr) chk("op_data", data_out, mon_it.val);
                        else                    chk("op_exp", exp_out, mon_it.val);
                    end
                end
            end
        end
        prev_tas   <= tas;
        pause_prev <= pause_seen && busy_out;
    end

    task automatic check_idle(input string tag);
        chk({tag, "_hold"}, hold_out, 1);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_strobes"}, int'({s_out, r_out, we_out, re_out}), 0);
        chk({tag, "_elem"}, elem_out, 0);
    endtask

    // One full run; pause_len cycles of pause starting at busy cycle pk; start optionally held.
    task automatic do_run(input int pause_len, input int pk, input bit keep_start);
        int busy = 0;
        int cyc = 0;
        n_wr = 0;
        n_rd = 0;
        push_run();
        start_in = 1'b1;
        @(negedge clk);
        if (!keep_start) start_in = 1'b0;
        chk("run_busy_rise", busy_out, 1);
        chk("run_done_clear", done_out, 0);
        while (busy_out && cyc < 400) begin
            busy++;
            if (pause_len > 0 && busy == pk) pause_in = 1'b1;
            if (busy == pk + pause_len) pause_in = 1'b0;
            if (keep_start && busy == 150) start_in = 1'b0;
            @(negedge clk);
            cyc++;
        end
        pause_in = 1'b0;
        chk("run_busy_len", busy, BaseBusy + pause_len);
        chk("run_done", done_out, 1);
        chk("run_writes", n_wr, 80);
        chk("run_reads", n_rd, 80);
        chk("run_sb_empty", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        chk("run_done_stays", done_out, 1);
        chk("run_no_restart", busy_out, 0);
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        do_run(0, 0, 1'b0);
        do_run(5, 60, 1'b0);  // pause inside E2
        for (int i = 0; i < 3; i++) begin
            do_run(int'($urandom_range(1, 6)), int'($urandom_range(10, 140)), 1'b0);
        end
        do_run(0, 0, 1'b1);

        // Reset in the middle of E4
        push_run();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        cyc = 0;
        while (elem_out != 3'd4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_e4", elem_out, 4);
        repeat (int'($urandom_range(2, 20))) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        do_run(0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
